// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the core memory stage and a
// byte-addressed data RAM that only handles aligned accesses.
//
// Ports
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_load/req_store         request kind (exactly one must be set)
//   req_funct3                 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata        byte address, store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse with extended load data
//   busy                       controller not idle
//   mem_load/mem_store         RAM strobes, one cycle per RAM op
//   mem_access, mem_addr, mem_wdata  RAM op size code, address, store data
//   mem_rdata                  RAM registered read data (cycle after mem_load)
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a request, req_ready high
// S_ISSUE   | a RAM strobe is on the bus this cycle
// S_CAPTURE | RAM read data valid, sampled at the end of this cycle
// S_RESP    | rsp_valid pulse for a completed request
// S_ERR     | rsp_valid + rsp_err pulse for an illegal request
module lsu_ctrl #(
  parameter int ADDR_WIDTH       = 12,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_ERR     = 3'd4;

  localparam logic [31:0] ADDR_MASK = 32'((33'd1 << ADDR_WIDTH) - 33'd1);

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        load_q;
  logic        split_q;
  logic [31:0] data_q;

  logic        misal, req_legal, req_split, last_byte;
  logic [1:0]  next_k;
  logic [31:0] next_addr;
  logic [31:0] cap_data;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'b0, d[7:0]};
      3'b101:  extend = {16'b0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_legal = 1'b0;
    if (req_load && !req_store)
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    else if (req_store && !req_load)
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    if (!SPLIT_MISALIGNED && misal)
      req_legal = 1'b0;
    req_split = SPLIT_MISALIGNED && misal;
  end

  // Halfwords split into 2 bytes, words into 4.
  assign last_byte = (f3_q[1:0] == 2'b01) ? (cnt == 2'd1) : (cnt == 2'd3);
  assign next_k    = cnt + 2'd1;
  assign next_addr = (addr_q + {30'b0, next_k}) & ADDR_MASK;

  always_comb begin
    cap_data = data_q;
    cap_data[{cnt, 3'b000} +: 8] = mem_rdata[7:0];
    if (!split_q)
      cap_data = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      f3_q       <= 3'b0;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      load_q     <= 1'b0;
      split_q    <= 1'b0;
      data_q     <= 32'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'b0;
      rsp_err    <= 1'b0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      mem_access <= 3'b0;
      mem_addr   <= 32'b0;
      mem_wdata  <= 32'b0;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'b0;
      rsp_err    <= 1'b0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      mem_access <= 3'b0;
      mem_addr   <= 32'b0;
      mem_wdata  <= 32'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            load_q  <= req_load;
            split_q <= req_split;
            cnt     <= 2'd0;
            data_q  <= 32'b0;
            if (!req_legal) begin
              state     <= S_ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              mem_load  <= req_load;
              mem_store <= req_store;
              if (req_split) begin
                mem_access <= req_load ? 3'b100 : 3'b000;
                mem_addr   <= req_addr & ADDR_MASK;
                mem_wdata  <= req_store ? {24'b0, req_wdata[7:0]} : 32'b0;
              end else begin
                mem_access <= req_funct3;
                mem_addr   <= req_addr;
                mem_wdata  <= req_store ? req_wdata : 32'b0;
              end
            end
          end
        end
        S_ISSUE: begin
          if (load_q) begin
            state <= S_CAPTURE;
          end else if (split_q && !last_byte) begin
            cnt        <= next_k;
            mem_store  <= 1'b1;
            mem_access <= 3'b000;
            mem_addr   <= next_addr;
            mem_wdata  <= {24'b0, wdata_q[{next_k, 3'b000} +: 8]};
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_CAPTURE: begin
          data_q <= cap_data;
          if (split_q && !last_byte) begin
            cnt        <= next_k;
            state      <= S_ISSUE;
            mem_load   <= 1'b1;
            mem_access <= 3'b100;
            mem_addr   <= next_addr;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            // RAM-side extension is not trusted; rebuild it from the request.
            rsp_rdata <= extend(f3_q, cap_data);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a byte-array RAM model.
// A second instance with SPLIT_MISALIGNED=0 covers misaligned rejection.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_load, mem_store;
  logic [2:0]  mem_access;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        ns_req_valid, ns_req_load, ns_req_store;
  logic [2:0]  ns_req_funct3;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_busy;
  logic [31:0] ns_rsp_rdata;
  logic        ns_mem_load, ns_mem_store;
  logic [2:0]  ns_mem_access;
  logic [31:0] ns_mem_addr, ns_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(12), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.ADDR_WIDTH(12), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rstn(rstn),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_load(ns_req_load),
    .req_store(ns_req_store), .req_funct3(ns_req_funct3), .req_addr(ns_req_addr),
    .req_wdata(ns_req_wdata), .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata),
    .rsp_err(ns_rsp_err), .busy(ns_busy), .mem_load(ns_mem_load), .mem_store(ns_mem_store),
    .mem_access(ns_mem_access), .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
    .mem_rdata(32'h0)
  );

  // RAM model: aligned ops only; fills unused upper bits with junk so the
  // LSU has to do its own extension.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_store) begin
      case (mem_access)
        3'b000: ram[mem_addr[11:0]] <= mem_wdata[7:0];
        3'b001: for (int i = 0; i < 2; i++) ram[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
        default: for (int i = 0; i < 4; i++) ram[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
      endcase
    end
    if (mem_load) begin
      case (mem_access)
        3'b000, 3'b100: mem_rdata <= {24'hDEADBE, ram[mem_addr[11:0]]};
        3'b001, 3'b101: mem_rdata <= {16'hDEAD, ram[mem_addr[11:0] + 12'd1], ram[mem_addr[11:0]]};
        default: mem_rdata <= {ram[mem_addr[11:0] + 12'd3], ram[mem_addr[11:0] + 12'd2],
                               ram[mem_addr[11:0] + 12'd1], ram[mem_addr[11:0]]};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations of the last transaction.
  int          r_cyc, nld, nst, extra_rsp;
  logic [31:0] r_data;
  logic        r_err, both_bad, ready_bad, busy_bad, ready_after;
  logic [31:0] ld_addr [8];
  logic [31:0] st_addr [8];
  logic [31:0] st_wd   [8];
  logic [2:0]  ld_acc  [8];
  logic [2:0]  st_acc  [8];

  task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic hold);
    int bound;
    @(negedge clk);
    bound = 0;
    while (!req_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    r_cyc = 0; nld = 0; nst = 0; extra_rsp = 0; r_data = 32'hx; r_err = 1'bx;
    both_bad = 0; ready_bad = 0; busy_bad = 0; ready_after = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Fields may change after acceptance; with hold, valid stays up while busy.
        req_valid = hold; req_load = 1'b0; req_store = 1'b1;
        req_funct3 = 3'b000; req_addr = 32'h3FF; req_wdata = 32'hEE;
      end
      if (mem_load) begin
        if (nld < 8) begin ld_addr[nld] = mem_addr; ld_acc[nld] = mem_access; end
        nld++;
      end
      if (mem_store) begin
        if (nst < 8) begin st_addr[nst] = mem_addr; st_wd[nst] = mem_wdata; st_acc[nst] = mem_access; end
        nst++;
      end
      if (mem_load && mem_store) both_bad = 1;
      if (busy == req_ready) busy_bad = 1;
      if (rsp_valid && r_cyc == 0) begin
        r_cyc = c; r_data = rsp_rdata; r_err = rsp_err;
        req_valid = 1'b0;
      end else if (rsp_valid) begin
        extra_rsp++;
      end
      if (r_cyc == 0 && req_ready) ready_bad = 1;
      if (r_cyc != 0 && c == r_cyc + 1) begin
        ready_after = req_ready;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int cyc, input int eld, input int est,
                           input logic [31:0] edata, input logic eerr);
    chk({tag, "_cyc"}, 32'(r_cyc), 32'(cyc));
    chk({tag, "_rdata"}, r_data, edata);
    chk({tag, "_err"}, 32'(r_err), 32'(eerr));
    chk({tag, "_nload"}, 32'(nld), 32'(eld));
    chk({tag, "_nstore"}, 32'(nst), 32'(est));
    chk({tag, "_both"}, 32'(both_bad), 32'd0);
    chk({tag, "_ready_busy"}, 32'(ready_bad), 32'd0);
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_extra_rsp"}, 32'(extra_rsp), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready_after), 32'd1);
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    ns_req_valid = 0; ns_req_load = 0; ns_req_store = 0; ns_req_funct3 = 0;
    ns_req_addr = 0; ns_req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_strobes", 32'({mem_load, mem_store}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Aligned SW then LW at 0x010.
    run_req(0, 1, 3'b010, 32'h010, 32'h8899AABB, 0);
    check_txn("sw_010", 2, 0, 1, 32'h0, 0);
    chk("sw_010_wdata", st_wd[0], 32'h8899AABB);
    chk("sw_010_acc", 32'(st_acc[0]), 32'd2);
    run_req(1, 0, 3'b010, 32'h010, 32'h0, 1);
    check_txn("lw_010", 3, 1, 0, 32'h8899AABB, 0);
    chk("lw_010_addr", ld_addr[0], 32'h010);
    chk("lw_010_acc", 32'(ld_acc[0]), 32'd2);

    // Byte/halfword extension around 0x013 = 0x80.
    run_req(0, 1, 3'b000, 32'h013, 32'h12345680, 0);
    check_txn("sb_013", 2, 0, 1, 32'h0, 0);
    run_req(1, 0, 3'b000, 32'h013, 32'h0, 0);
    check_txn("lb_013", 3, 1, 0, 32'hFFFFFF80, 0);
    run_req(1, 0, 3'b100, 32'h013, 32'h0, 0);
    check_txn("lbu_013", 3, 1, 0, 32'h00000080, 0);
    run_req(1, 0, 3'b001, 32'h012, 32'h0, 0);
    check_txn("lh_012", 3, 1, 0, 32'hFFFF8099, 0);
    run_req(1, 0, 3'b101, 32'h012, 32'h0, 0);
    check_txn("lhu_012", 3, 1, 0, 32'h00008099, 0);

    // Misaligned word store/load split into bytes.
    run_req(0, 1, 3'b010, 32'h005, 32'h11223344, 1);
    check_txn("sw_005", 5, 0, 4, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sw_005_addr%0d", k), st_addr[k], 32'h005 + 32'(k));
      chk($sformatf("sw_005_wd%0d", k), st_wd[k], {24'h0, 8'h44 - 8'(k * 8'h11)});
      chk($sformatf("sw_005_acc%0d", k), 32'(st_acc[k]), 32'd0);
    end
    run_req(1, 0, 3'b010, 32'h005, 32'h0, 0);
    check_txn("lw_005", 9, 4, 0, 32'h11223344, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lw_005_addr%0d", k), ld_addr[k], 32'h005 + 32'(k));
      chk($sformatf("lw_005_acc%0d", k), 32'(ld_acc[k]), 32'd4);
    end

    // Halfword wrapping the 12-bit address space.
    run_req(0, 1, 3'b000, 32'hFFF, 32'h80, 0);
    check_txn("sb_fff", 2, 0, 1, 32'h0, 0);
    run_req(0, 1, 3'b000, 32'h000, 32'hFF, 0);
    check_txn("sb_000", 2, 0, 1, 32'h0, 0);
    run_req(1, 0, 3'b001, 32'hFFF, 32'h0, 0);
    check_txn("lh_fff", 5, 2, 0, 32'hFFFFFF80, 0);
    chk("lh_fff_addr0", ld_addr[0], 32'hFFF);
    chk("lh_fff_addr1", ld_addr[1], 32'h000);
    run_req(1, 0, 3'b101, 32'hFFF, 32'h0, 0);
    check_txn("lhu_fff", 5, 2, 0, 32'h0000FF80, 0);

    // Illegal requests.
    run_req(1, 1, 3'b010, 32'h010, 32'h0, 0);
    check_txn("ill_ldst", 1, 0, 0, 32'h0, 1);
    run_req(1, 0, 3'b011, 32'h010, 32'h0, 0);
    check_txn("ill_ld011", 1, 0, 0, 32'h0, 1);
    run_req(0, 1, 3'b100, 32'h010, 32'h0, 0);
    check_txn("ill_st100", 1, 0, 0, 32'h0, 1);
    run_req(0, 0, 3'b010, 32'h010, 32'h0, 0);
    check_txn("ill_none", 1, 0, 0, 32'h0, 1);

    // SPLIT_MISALIGNED=0 instance.
    @(negedge clk);
    ns_req_valid = 1; ns_req_load = 1; ns_req_funct3 = 3'b010; ns_req_addr = 32'h002;
    @(posedge clk);
    @(negedge clk);
    ns_req_valid = 0;
    chk("ns_lw002_valid", 32'(ns_rsp_valid), 32'd1);
    chk("ns_lw002_err", 32'(ns_rsp_err), 32'd1);
    chk("ns_lw002_rdata", ns_rsp_rdata, 32'h0);
    chk("ns_lw002_strobe", 32'({ns_mem_load, ns_mem_store}), 32'd0);
    @(negedge clk);
    ns_req_valid = 1; ns_req_load = 0; ns_req_store = 1; ns_req_funct3 = 3'b000;
    ns_req_addr = 32'h003; ns_req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    ns_req_valid = 0;
    chk("ns_sb003_store", 32'(ns_mem_store), 32'd1);
    chk("ns_sb003_addr", ns_mem_addr, 32'h003);
    @(negedge clk);
    chk("ns_sb003_valid", 32'(ns_rsp_valid), 32'd1);
    chk("ns_sb003_err", 32'(ns_rsp_err), 32'd0);

    // Reset in cycle 2 of a split SW at 0x021.
    @(negedge clk);
    req_valid = 1; req_load = 0; req_store = 1; req_funct3 = 3'b010;
    req_addr = 32'h021; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("abort_c1_store", 32'(mem_store), 32'd1);
    chk("abort_c1_addr", mem_addr, 32'h021);
    @(negedge clk);
    chk("abort_c2_addr", mem_addr, 32'h022);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_c3_strobes", 32'({mem_load, mem_store}), 32'd0);
    chk("abort_c3_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_c3_busy", 32'(busy), 32'd0);
    chk("abort_c3_addr", mem_addr, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    run_req(1, 0, 3'b101, 32'h021, 32'h0, 0);
    check_txn("lhu_021", 5, 2, 0, 32'h0000F00D, 0);
    run_req(1, 0, 3'b010, 32'h010, 32'h0, 0);
    check_txn("lw_010_post", 3, 1, 0, 32'h8099AABB, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
